// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO buffering {pc, instruction} pairs; flush empties it in one edge.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [WIDTH-1:0] last;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // The last popped entry is kept so the outputs hold steady while empty.
  assign dout = empty ? last : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      if (do_pop) begin
        last <= mem[rd_ptr];
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, imem req/ack FSM, {pc,inst} buffer and redirect flush.
// Optional FETCH_STATS_EN adds stat_fetched / stat_stall counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [31:0]       inst_pc,
  output logic [31:0]       inst_pc_plus4
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_addr;
  logic             latch_req;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  always_comb begin
    state_next = state;
    latch_req  = 1'b0;
    push       = 1'b0;
    case (state)
      FS_IDLE: begin
        if (!redirect_valid && (count < CNT_W'(FIFO_DEPTH))) begin
          state_next = FS_WAIT;
          latch_req  = 1'b1;
        end
      end
      FS_WAIT: begin
        if (redirect_valid) begin
          state_next = imem_ack ? FS_IDLE : FS_DRAIN;
        end else if (imem_ack) begin
          push       = ~full;
          state_next = FS_IDLE;
        end
      end
      FS_DRAIN: begin
        if (imem_ack) begin
          state_next = FS_IDLE;
        end
      end
      default: state_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'd3;
      end else if (push) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (latch_req) begin
        req_addr <= fetch_pc;
      end
    end
  end

  assign imem_req  = (state != FS_IDLE);
  assign imem_addr = req_addr;

  assign wr_entry.pc   = req_addr;
  assign wr_entry.inst = imem_rdata;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign inst_valid    = ~empty;
  assign pop           = inst_valid & inst_ready;
  assign inst_data     = head.inst;
  assign inst_pc       = head.pc;
  assign inst_pc_plus4 = head.pc + PC_STEP;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_stall   <= '0;
    end else begin
      if (pop) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (inst_ready && !inst_valid) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule
